jt89_ctrl: RTL and testbench
============================

JT89_CTRL -- requirements
Module: jt89_ctrl

Interface
REQ-001 Parameter: READY_CYCLES, default 32, number of cen ticks the ready output stays low after an accepted write; range 0..255.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cen  input  1  clock enable; gates only the busy counter.
REQ-005 din  input  8  CPU write data byte.
REQ-006 wr_n  input  1  CPU write strobe, active-low, level.
REQ-007 ready  output  1  high = write will be accepted; low = busy.
REQ-008 tone0, tone1, tone2  output  10 each  tone period per channel.
REQ-009 vol0, vol1, vol2, vol3  output  4 each  attenuation per channel (vol3 = noise); 4'hF = silent.
REQ-010 ctrl3  output  3  noise control (bit2 = white/periodic, bits1:0 = rate).
REQ-011 noise_rst  output  1  one-clk pulse on every noise-control write.

Function
REQ-012 The block SHALL register wr_n every clk into wr_n_l.
REQ-013 A write SHALL be accepted in the cycle where wr_n==0, wr_n_l==1 and ready==1; only one write per falling edge, whatever the hold time.
REQ-014 A falling edge with ready==0 SHALL be discarded with no state change; it is not queued.
REQ-015 Latch byte (din[7]==1): latched register addr = din[6:4] (ch = din[6:5], type = din[4], 1 = volume); data din[3:0] applied immediately.
REQ-016 Latch, tone (ch 0..2): tone_ch[3:0] <= din[3:0]; tone_ch[9:4] unchanged.
REQ-017 Latch, volume (ch 0..3): vol_ch <= din[3:0].
REQ-018 Latch, addr 3'b110 (noise control): ctrl3 <= din[2:0]; noise_rst asserted.
REQ-019 Data byte (din[7]==0) SHALL target the currently latched addr; the addr is not changed.
REQ-020 Data, tone: tone_ch[9:4] <= din[5:0]; tone_ch[3:0] unchanged.
REQ-021 Data, volume: vol_ch <= din[3:0].
REQ-022 Data, noise control: ctrl3 <= din[2:0]; noise_rst asserted.
REQ-023 Latency: outputs SHALL update at the clk edge ending the accept cycle; noise_rst high for exactly that following cycle.
REQ-024 On accept with READY_CYCLES>0: ready <= 0, cnt <= READY_CYCLES at the same edge.
REQ-025 While ready==0: on each cycle with cen==1, cnt decrements; at the edge where cen==1 and cnt==1, ready <= 1 and cnt <= 0.
REQ-026 cen==0 SHALL freeze cnt and ready.
REQ-027 READY_CYCLES==0: ready SHALL stay high permanently; every falling edge is accepted.
REQ-028 Falling edge in the same cycle that cnt reaches 1 with cen==1: discarded (ready still 0 that cycle).
REQ-029 Outputs SHALL be registered; no combinational path from din/wr_n to any output.

Reset
REQ-030 rst high SHALL asynchronously set: tone0..2 = 0, vol0..3 = 4'hF, ctrl3 = 0, latched addr = 3'b000, noise_rst = 0, ready = 1, cnt = 0, wr_n_l = 1.
REQ-031 Reset during busy SHALL abort the count; ready is 1 while rst is high and after release.
REQ-032 wr_n held low across reset release SHALL not produce a write; a new high-to-low transition is required.

Verification
REQ-033 Reset release, cen=1: check ready=1, vol0..3=F, tone0..2=0, ctrl3=0, noise_rst=0.
REQ-034 Write 0x8A, wait until ready, then write 0x3F: tone0=0x3FA; vol0 unchanged at F; ready low for exactly 32 cen ticks after each accept.
REQ-035 Write 0xE5: ctrl3=5; noise_rst one-cycle pulse; then data byte 0x02: ctrl3=2, second noise_rst pulse.
REQ-036 Write 0xB3, then a second falling edge with din=0x9F while ready=0: vol1=3, vol0 stays F, ready timing unaffected.
REQ-037 cen at 1-in-4 duty, write 0xD7: vol2=7; ready low for 128 clk; falling edge on the release cycle discarded.
REQ-038 Assert rst mid-busy after write 0xF0: ready=1 immediately, vol3=F; wr_n held low through release yields no write.

Source files
------------

// File: rtl/jt89_ctrl.sv
// SN76489-style register file: decodes CPU latch/data bytes into tone, volume and
// noise-control registers, and holds ready low for READY_CYCLES cen ticks after each write.
module jt89_ctrl #(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic       wr_n,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] ctrl3,
    output logic       noise_rst
);

    localparam logic [2:0] ADDR_NOISE = 3'b110;
    localparam logic [7:0] CNT_LOAD   = 8'(READY_CYCLES);

    logic       wr_n_l;
    logic       wr_armed;
    logic [2:0] addr;
    logic [7:0] cnt;
    logic [9:0] tone [3];
    logic [3:0] vol  [4];

    logic       accept;
    logic [2:0] target;

    // A latch byte rewrites only the low nibble of a tone; a data byte the upper six bits.
    function automatic logic [9:0] tone_upd(input logic [9:0] cur, input logic [7:0] d);
        return d[7] ? {cur[9:4], d[3:0]} : {d[5:0], cur[3:0]};
    endfunction

    // wr_n_l comes out of reset high, so wr_armed additionally demands that wr_n has
    // been seen high since reset; a strobe held low across release is not a write.
    always_comb begin
        accept = !wr_n && wr_n_l && wr_armed && ready;
        target = din[7] ? din[6:4] : addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_n_l    <= 1'b1;
            wr_armed  <= 1'b0;
            addr      <= 3'b000;
            ready     <= 1'b1;
            cnt       <= 8'd0;
            ctrl3     <= 3'd0;
            noise_rst <= 1'b0;
            for (int i = 0; i < 3; i++) tone[i] <= 10'd0;
            for (int i = 0; i < 4; i++) vol[i]  <= 4'hF;
        end else begin
            // NOTE: non-blocking throughout so every register samples the pre-edge
            // values of wr_n_l/ready/addr that produced accept and target.
            wr_n_l    <= wr_n;
            noise_rst <= 1'b0;
            if (wr_n) wr_armed <= 1'b1;

            if (accept) begin
                if (din[7]) addr <= din[6:4];
                case (target)
                    3'b000:     tone[0] <= tone_upd(tone[0], din);
                    3'b010:     tone[1] <= tone_upd(tone[1], din);
                    3'b100:     tone[2] <= tone_upd(tone[2], din);
                    ADDR_NOISE: begin
                        ctrl3     <= din[2:0];
                        noise_rst <= 1'b1;
                    end
                    default:    vol[target[2:1]] <= din[3:0];
                endcase
            end

            if (accept && READY_CYCLES != 0) begin
                ready <= 1'b0;
                cnt   <= CNT_LOAD;
            end else if (!ready && cen) begin
                if (cnt == 8'd1) begin
                    ready <= 1'b1;
                    cnt   <= 8'd0;
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end
    end

    assign tone0 = tone[0];
    assign tone1 = tone[1];
    assign tone2 = tone[2];
    assign vol0  = vol[0];
    assign vol1  = vol[1];
    assign vol2  = vol[2];
    assign vol3  = vol[3];

endmodule

// File: tb/tb_jt89_ctrl.sv
// Directed and random stimulus for jt89_ctrl, compared every cycle against a
// behavioural register-file model plus explicit checks of the documented scenarios.
module tb_jt89_ctrl;

    localparam int RC = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic       ready, noise_rst;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] vol0, vol1, vol2, vol3;
    logic [2:0] ctrl3;

    jt89_ctrl #(.READY_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .wr_n(wr_n),
        .ready(ready), .tone0(tone0), .tone1(tone1), .tone2(tone2),
        .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
        .ctrl3(ctrl3), .noise_rst(noise_rst)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: register contents as integers, busy as remaining cen ticks.
    int m_tone [3];
    int m_vol  [4];
    int m_ctrl3, m_addr, m_busy;
    bit m_noise, m_prev;

    function automatic logic [63:0] dut_vec();
        return {13'd0, ready, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, noise_rst};
    endfunction

    function automatic logic [63:0] model_vec();
        return {13'd0, (m_busy == 0), 10'(m_tone[0]), 10'(m_tone[1]), 10'(m_tone[2]),
                4'(m_vol[0]), 4'(m_vol[1]), 4'(m_vol[2]), 4'(m_vol[3]), 3'(m_ctrl3), m_noise};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A strobe low at reset release must not count as a falling edge, so prev starts low.
    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_tone[i] = 0;
        for (int i = 0; i < 4; i++) m_vol[i] = 15;
        m_ctrl3 = 0; m_addr = 0; m_busy = 0; m_noise = 0; m_prev = 0;
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic c);
        int tgt, ch;
        m_noise = 0;
        if (m_prev && !w && m_busy == 0) begin
            if (d[7]) m_addr = int'(d[6:4]);
            tgt = d[7] ? int'(d[6:4]) : m_addr;
            ch  = tgt / 2;
            if (tgt % 2 == 1)      m_vol[ch] = d % 16;
            else if (ch == 3) begin
                m_ctrl3 = d % 8;
                m_noise = 1;
            end else if (d[7])     m_tone[ch] = (m_tone[ch] / 16) * 16 + d % 16;
            else                   m_tone[ch] = (d % 64) * 16 + m_tone[ch] % 16;
            m_busy = RC;
        end else if (m_busy > 0 && c) begin
            m_busy--;
        end
        m_prev = w;
    endtask

    // One clock: drive at the falling edge, clock the DUT, compare at the next falling edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic c);
        wr_n = w; din = d; cen = c;
        model_step(w, d, c);
        @(posedge clk);
        @(negedge clk);
        check("cycle", dut_vec(), model_vec());
    endtask

    // Run until ready returns; g selects a loop index carrying an extra falling edge.
    task automatic wait_ready(input int period, input int g, input logic [7:0] gd, output int cnt);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc((i == g) ? 1'b0 : 1'b1, (i == g) ? gd : 8'h00, (i % period) == period - 1);
            cnt++;
            if (ready) break;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", dut_vec(), model_vec());
        check("reset_ready", {63'd0, ready}, 64'd1);
        cyc(1'b1, 8'h00, 1'b1);

        cyc(1'b0, 8'h8A, 1'b1);
        wait_ready(1, -1, 8'h00, c);
        check("busy_8A", 64'(c), 64'(RC));
        cyc(1'b0, 8'h3F, 1'b1);
        wait_ready(1, -1, 8'h00, c);
        check("busy_3F", 64'(c), 64'(RC));
        check("tone0", 64'(tone0), 64'h3FA);
        check("vol0_keep", 64'(vol0), 64'hF);

        cyc(1'b0, 8'hE5, 1'b1);
        check("ctrl3_E5", 64'(ctrl3), 64'd5);
        check("noise_pulse1", 64'(noise_rst), 64'd1);
        cyc(1'b1, 8'h00, 1'b1);
        check("noise_end1", 64'(noise_rst), 64'd0);
        wait_ready(1, -1, 8'h00, c);
        cyc(1'b0, 8'h02, 1'b1);
        check("ctrl3_02", 64'(ctrl3), 64'd2);
        check("noise_pulse2", 64'(noise_rst), 64'd1);
        cyc(1'b1, 8'h00, 1'b1);
        check("noise_end2", 64'(noise_rst), 64'd0);
        wait_ready(1, -1, 8'h00, c);

        cyc(1'b0, 8'hB3, 1'b1);
        wait_ready(1, 5, 8'h9F, c);
        check("busy_B3_glitch", 64'(c), 64'(RC));
        check("vol1", 64'(vol1), 64'd3);
        check("vol0_discard", 64'(vol0), 64'hF);

        cyc(1'b0, 8'hD7, 1'b1);
        wait_ready(4, 4 * RC - 1, 8'hDF, c);
        check("busy_cen4", 64'(c), 64'(4 * RC));
        check("vol2", 64'(vol2), 64'd7);
        cyc(1'b0, 8'hDF, 1'b1);
        check("vol2_release_discard", 64'(vol2), 64'd7);
        check("ready_after_release", {63'd0, ready}, 64'd1);
        cyc(1'b1, 8'h00, 1'b1);

        cyc(1'b0, 8'hF0, 1'b1);
        check("vol3_F0", 64'(vol3), 64'd0);
        repeat (3) cyc(1'b1, 8'h00, 1'b1);
        wr_n = 1'b0; din = 8'h90;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_ready", {63'd0, ready}, 64'd1);
        check("rst_async_vol3", 64'(vol3), 64'hF);
        check("rst_async_state", dut_vec(), model_vec());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(1'b0, 8'h90, 1'b1);
        check("no_write_after_rst", 64'(vol0), 64'hF);
        cyc(1'b1, 8'h90, 1'b1);
        cyc(1'b0, 8'h90, 1'b1);
        check("write_after_rst", 64'(vol0), 64'd0);
        wait_ready(1, -1, 8'h00, c);

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
